// File: rtl/text_pkg.sv
// Shared constants, state encoding and command record for the text-mode block-write engine.
// Optional reset-time screen clear is selected by TEXT_BLITTER_CLEAR_ON_RESET_EN.
package text_pkg;

    localparam int COLS   = 80;
    localparam int ROWS   = 25;
    localparam int CELLS  = COLS * ROWS;
    localparam int ADDR_W = 11;

    localparam logic [7:0] CH_BLANK = 8'h00;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_COPY_PRIME,
        ST_COPY,
`ifdef TEXT_BLITTER_CLEAR_ON_RESET_EN
        ST_DONE,
        ST_CLEAR
`else
        ST_DONE
`endif
    } state_t;

    typedef struct packed {
        addr_t      end_cell;
        logic [7:0] data;
    } cmd_t;

    function automatic addr_t clamp_end(input addr_t e);
        return (e > addr_t'(CELLS)) ? addr_t'(CELLS) : e;
    endfunction

endpackage

// File: rtl/text_blitter_if.sv
// Command strobe/status and character-RAM port bundle between control logic and the blitter.
// master = terminal control + RAM side, slave = blitter.
interface text_blitter_if;
    import text_pkg::*;

    logic       wr_start;
    addr_t      wr_begin;
    addr_t      wr_end;
    logic [7:0] wr_data;
    logic [7:0] wr_offset;
    logic       wr_busy;
    logic       wr_complete;
    addr_t      mem_raddr;
    logic [7:0] mem_rdata;
    logic       mem_we;
    addr_t      mem_waddr;
    logic [7:0] mem_wdata;

    modport master (
        output wr_start, wr_begin, wr_end, wr_data, wr_offset, mem_rdata,
        input  wr_busy, wr_complete, mem_raddr, mem_we, mem_waddr, mem_wdata
    );

    modport slave (
        input  wr_start, wr_begin, wr_end, wr_data, wr_offset, mem_rdata,
        output wr_busy, wr_complete, mem_raddr, mem_we, mem_waddr, mem_wdata
    );

endinterface

// File: rtl/text_blitter.sv
// Fill/copy engine: one RAM write per cycle, fill N cells done at N+1, copy at N+2; wr_start ignored while busy.
// TEXT_BLITTER_CLEAR_ON_RESET_EN adds a CLEAR pass writing blanks to every cell after reset.
module text_blitter
    import text_pkg::*;
(
    input  logic          clk100,
    input  logic          rst,
    text_blitter_if.slave bus
);

`ifdef TEXT_BLITTER_CLEAR_ON_RESET_EN
    localparam state_t RESET_STATE = ST_CLEAR;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif
    localparam logic [ADDR_W:0] SRC_LIMIT = (ADDR_W+1)'(CELLS);

    state_t          state, state_nxt;
    cmd_t            cmd_q, cmd_nxt;
    addr_t           dest, dest_nxt, waddr_q, waddr_nxt, raddr_q, raddr_nxt;
    addr_t           end_clamped;
    logic [ADDR_W:0] src, src_nxt, src_start;
    logic            we_q, we_nxt, busy_q, busy_nxt, done_q, done_nxt;
    logic            copy_q, copy_nxt, rd_oob_q, rd_oob_nxt, wr_oob_q, wr_oob_nxt;
    logic            cmd_empty, cmd_fill, range_done;

    assign end_clamped = clamp_end(bus.wr_end);
    assign cmd_empty   = bus.wr_begin >= end_clamped;
    assign cmd_fill    = bus.wr_offset == 8'h00;
    assign src_start   = {1'b0, bus.wr_begin} + (ADDR_W+1)'(bus.wr_offset);
    assign range_done  = dest == cmd_q.end_cell;

    always_ff @(posedge clk100) begin
        if (rst) state <= RESET_STATE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.wr_start) begin
                    if (cmd_empty)     state_nxt = ST_DONE;
                    else if (cmd_fill) state_nxt = ST_FILL;
                    else               state_nxt = ST_COPY_PRIME;
                end
            end
            ST_FILL, ST_COPY: if (range_done) state_nxt = ST_DONE;
            ST_COPY_PRIME:    state_nxt = ST_COPY;
            ST_DONE:          state_nxt = ST_IDLE;
`ifdef TEXT_BLITTER_CLEAR_ON_RESET_EN
            ST_CLEAR:         if (range_done) state_nxt = ST_IDLE;
`endif
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // dest always holds the next cell to write; the write visible this cycle is waddr_q.
    always_comb begin
        cmd_nxt    = cmd_q;
        dest_nxt   = dest;
        src_nxt    = src;
        waddr_nxt  = waddr_q;
        raddr_nxt  = raddr_q;
        rd_oob_nxt = rd_oob_q;
        wr_oob_nxt = wr_oob_q;
        we_nxt     = 1'b0;
        copy_nxt   = 1'b0;
        busy_nxt   = state_nxt != ST_IDLE;
        done_nxt   = state_nxt == ST_DONE;
        case (state)
            ST_IDLE: begin
                if (bus.wr_start && !cmd_empty) begin
                    cmd_nxt.end_cell = end_clamped;
                    cmd_nxt.data     = bus.wr_data;
                    if (cmd_fill) begin
                        we_nxt    = 1'b1;
                        waddr_nxt = bus.wr_begin;
                        dest_nxt  = bus.wr_begin + addr_t'(1);
                    end else begin
                        raddr_nxt  = src_start[ADDR_W-1:0];
                        rd_oob_nxt = src_start >= SRC_LIMIT;
                        src_nxt    = src_start + (ADDR_W+1)'(1);
                        dest_nxt   = bus.wr_begin;
                    end
                end
            end
`ifdef TEXT_BLITTER_CLEAR_ON_RESET_EN
            ST_FILL, ST_CLEAR: begin
`else
            ST_FILL: begin
`endif
                if (!range_done) begin
                    we_nxt    = 1'b1;
                    waddr_nxt = dest;
                    dest_nxt  = dest + addr_t'(1);
                end
            end
            ST_COPY_PRIME, ST_COPY: begin
                // Write the cell whose source was read this cycle, and read one source ahead.
                if (state == ST_COPY_PRIME || !range_done) begin
                    we_nxt     = 1'b1;
                    copy_nxt   = 1'b1;
                    waddr_nxt  = dest;
                    wr_oob_nxt = rd_oob_q;
                    dest_nxt   = dest + addr_t'(1);
                    raddr_nxt  = src[ADDR_W-1:0];
                    rd_oob_nxt = src >= SRC_LIMIT;
                    src_nxt    = src + (ADDR_W+1)'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk100) begin
        if (rst) begin
            cmd_q    <= cmd_t'{end_cell: addr_t'(CELLS), data: CH_BLANK};
            dest     <= '0;
            src      <= '0;
            waddr_q  <= '0;
            raddr_q  <= '0;
            rd_oob_q <= 1'b0;
            wr_oob_q <= 1'b0;
            we_q     <= 1'b0;
            copy_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cmd_q    <= cmd_nxt;
            dest     <= dest_nxt;
            src      <= src_nxt;
            waddr_q  <= waddr_nxt;
            raddr_q  <= raddr_nxt;
            rd_oob_q <= rd_oob_nxt;
            wr_oob_q <= wr_oob_nxt;
            we_q     <= we_nxt;
            copy_q   <= copy_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
        end
    end

    assign bus.wr_busy     = busy_q;
    assign bus.wr_complete = done_q;
    assign bus.mem_we      = we_q;
    assign bus.mem_waddr   = waddr_q;
    assign bus.mem_raddr   = raddr_q;
    // Copy data comes straight from the RAM read register, aligned with the registered write address.
    assign bus.mem_wdata   = copy_q ? (wr_oob_q ? CH_BLANK : bus.mem_rdata) : cmd_q.data;

endmodule

// File: tb/tb_text_blitter.sv
// Directed bench for text_blitter with a behavioural 1-cycle-read character RAM.
module tb_text_blitter;
    import text_pkg::*;

    logic clk100 = 1'b0;
    logic rst;
    text_blitter_if bus();

    text_blitter dut (
        .clk100 (clk100),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk100 = ~clk100;

    logic [7:0] ram [0:2047];
    always @(posedge clk100) begin
        if (bus.mem_we) ram[bus.mem_waddr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_raddr];
    end

    int checks = 0;
    int errors = 0;
    int n_wr, n_cmp, cmp_cyc, n_busy, first_wr, last_wr, bad;
    logic [10:0] wa [$];
    logic [7:0]  wd [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Cycle k = k-th cycle after the one in which wr_start is driven high.
    task automatic run(input logic [10:0] b, input logic [10:0] e, input logic [7:0] d,
                       input logic [7:0] o, input int budget, input int inj_cyc, input int rst_cyc);
        n_wr = 0; n_cmp = 0; cmp_cyc = -1; n_busy = 0; first_wr = 0; last_wr = 0;
        wa.delete(); wd.delete();
        @(negedge clk100);
        bus.wr_begin = b; bus.wr_end = e; bus.wr_data = d; bus.wr_offset = o; bus.wr_start = 1'b1;
        @(negedge clk100);
        bus.wr_start = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            if (bus.mem_we) begin
                n_wr++;
                if (n_wr == 1) first_wr = k;
                last_wr = k;
                wa.push_back(bus.mem_waddr);
                wd.push_back(bus.mem_wdata);
            end
            if (bus.wr_complete) begin
                n_cmp++;
                if (cmp_cyc < 0) cmp_cyc = k;
            end
            if (bus.wr_busy) n_busy++;
            if (k == inj_cyc) begin
                bus.wr_begin = 11'd50; bus.wr_end = 11'd60; bus.wr_data = 8'h5A;
                bus.wr_offset = 8'h00; bus.wr_start = 1'b1;
            end else begin
                bus.wr_start = 1'b0;
            end
            rst = (k == rst_cyc);
            if (cmp_cyc >= 0 && k >= cmp_cyc + 4) break;
            @(negedge clk100);
        end
        bus.wr_start = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        bus.wr_start = 1'b0; bus.wr_begin = '0; bus.wr_end = '0;
        bus.wr_data = '0; bus.wr_offset = '0;
        for (int i = 0; i < 2048; i++) ram[i] = 8'(i);
        rst = 1'b1;
        repeat (3) @(negedge clk100);
        check("rst_busy",     bus.wr_busy,     0);
        check("rst_complete", bus.wr_complete, 0);
        check("rst_we",       bus.mem_we,      0);
        check("rst_raddr",    bus.mem_raddr,   0);
        check("rst_waddr",    bus.mem_waddr,   0);
        check("rst_wdata",    bus.mem_wdata,   0);
        rst = 1'b0;

`ifdef TEXT_BLITTER_CLEAR_ON_RESET_EN
        n_wr = 0; n_cmp = 0; bad = 0;
        bus.wr_begin = 11'd0; bus.wr_end = 11'd5; bus.wr_data = 8'hAA; bus.wr_offset = 8'h00;
        for (int k = 0; k < 2100; k++) begin
            @(negedge clk100);
            if (bus.mem_we) begin
                if (bus.mem_waddr != 11'(n_wr) || bus.mem_wdata != 8'h00 || !bus.wr_busy) bad++;
                n_wr++;
            end
            if (bus.wr_complete) n_cmp++;
            bus.wr_start = (k == 100);
            if (k > 5 && !bus.wr_busy && !bus.mem_we) break;
        end
        bus.wr_start = 1'b0;
        check("clear_writes",   n_wr,  2000);
        check("clear_bad",      bad,   0);
        check("clear_complete", n_cmp, 0);
        for (int i = 0; i < 2048; i++) ram[i] = 8'(i);
`endif

        run(11'd5, 11'd8, 8'h41, 8'h00, 40, -1, -1);
        check("fill_nwr", n_wr, 3);
        check("fill_first", first_wr, 1);
        check("fill_last", last_wr, 3);
        for (int i = 0; i < 3; i++) begin
            check("fill_addr", (i < wa.size()) ? 32'(wa[i]) : 32'hFFFF_FFFF, 5 + i);
            check("fill_data", (i < wd.size()) ? 32'(wd[i]) : 32'hFFFF_FFFF, 32'h41);
        end
        check("fill_cmp_cyc", cmp_cyc, 4);
        check("fill_ncmp", n_cmp, 1);
        check("fill_busy_cycles", n_busy, 4);

        run(11'd0, 11'd1920, 8'h00, 8'd80, 2000, -1, -1);
        check("scroll_cmp_cyc", cmp_cyc, 1922);
        check("scroll_nwr", n_wr, 1920);
        check("scroll_first", first_wr, 2);
        check("scroll_busy_cycles", n_busy, 1922);
        bad = 0;
        for (int i = 0; i < 1920; i++) if (ram[i] != 8'(i + 80)) bad++;
        check("scroll_data", bad, 0);
        bad = 0;
        for (int i = 1920; i < 2000; i++) if (ram[i] != 8'(i)) bad++;
        check("scroll_tail", bad, 0);

        for (int i = 1990; i < 2000; i++) ram[i] = 8'hEE;
        for (int i = 2000; i < 2048; i++) ram[i] = 8'h77;
        run(11'd1970, 11'd1990, 8'h00, 8'd20, 60, -1, -1);
        check("straddle_nwr", n_wr, 20);
        check("straddle_cmp_cyc", cmp_cyc, 22);
        bad = 0;
        for (int i = 1970; i < 1980; i++) if (ram[i] != 8'hEE) bad++;
        for (int i = 1980; i < 1990; i++) if (ram[i] != 8'h00) bad++;
        check("straddle_data", bad, 0);

        run(11'd1990, 11'd2000, 8'h00, 8'd20, 40, -1, -1);
        check("past_end_nwr", n_wr, 10);
        check("past_end_cmp_cyc", cmp_cyc, 12);
        bad = 0;
        for (int i = 0; i < wa.size(); i++) if (wa[i] != 11'(1990 + i) || wd[i] != 8'h00) bad++;
        for (int i = 1990; i < 2000; i++) if (ram[i] != 8'h00) bad++;
        check("past_end_data", bad, 0);

        run(11'd100, 11'd100, 8'h21, 8'h00, 20, -1, -1);
        check("empty_nwr", n_wr, 0);
        check("empty_cmp_cyc", cmp_cyc, 1);
        check("empty_busy_cycles", n_busy, 1);

        run(11'd500, 11'd400, 8'h21, 8'd3, 20, -1, -1);
        check("reverse_nwr", n_wr, 0);
        check("reverse_cmp_cyc", cmp_cyc, 1);

        run(11'd1998, 11'd2040, 8'h33, 8'h00, 20, -1, -1);
        check("clamp_nwr", n_wr, 2);
        check("clamp_cmp_cyc", cmp_cyc, 3);
        check("clamp_last_addr", (wa.size() == 2) ? 32'(wa[1]) : 32'hFFFF_FFFF, 1999);

        run(11'd10, 11'd13, 8'h42, 8'h00, 40, 2, -1);
        check("reject_nwr", n_wr, 3);
        check("reject_ncmp", n_cmp, 1);
        check("reject_cmp_cyc", cmp_cyc, 4);
        check("reject_last_addr", (wa.size() == 3) ? 32'(wa[2]) : 32'hFFFF_FFFF, 12);

`ifndef TEXT_BLITTER_CLEAR_ON_RESET_EN
        run(11'd200, 11'd210, 8'h55, 8'h00, 20, -1, 3);
        check("abort_nwr", n_wr, 3);
        check("abort_last", last_wr, 3);
        check("abort_ncmp", n_cmp, 0);
        check("abort_busy_cycles", n_busy, 3);
        check("abort_busy_end", bus.wr_busy, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
